alu_seq: RTL

Parameterised, handshaked successor to the team's 8-bit combinational ALU. It keeps the same operand/opcode model and adds the following:
- registered outputs with valid/ready flow control;
- status flags;
- iterative unsigned multiply and divide with a high-half/remainder output.

It sits between the decode/register-read stage and writeback, and it stalls upstream while a multi-cycle operation is in flight.

---
 rtl/alu_seq.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative unsigned multiply
// and restoring divide, with registered result, high half/remainder and flags.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam logic [WIDTH-1:0] W_B  = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t               state_r, state_s;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [3:0]           op_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r, acc_s;

  logic                 iter_s, load_s;
  logic [WIDTH-1:0]     res_s, hi_s;
  logic                 c_s, v_s, err_s;
  logic [1:0]           zn_s;

  logic [WIDTH:0]       sum_s, diff_s;
  logic [WIDTH:0]       mul_sum_s, div_sh_s, div_sub_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_rem_s;
  logic                 unused_s;

  function automatic logic [1:0] zn_flags(input logic [WIDTH-1:0] r);
    return {~|r, r[WIDTH-1]};
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

  assign iter_s = (alu_ctrl == OP_MUL) || ((alu_ctrl == OP_DIV) && (b != {WIDTH{1'b0}}));

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, dividend/quotient}.
  assign mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
  assign div_sh_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign div_ge_s  = (div_sh_s >= {1'b0, b_r});
  assign div_sub_s = div_sh_s - {1'b0, b_r};
  assign div_rem_s = div_ge_s ? div_sub_s[WIDTH-1:0] : div_sh_s[WIDTH-1:0];
  assign unused_s  = div_sub_s[WIDTH];

  // One shift-add or restoring-divide step per BUSY cycle.
  always_comb begin
    acc_s = acc_r;
    if (op_r == OP_MUL) begin
      acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else begin
      acc_s = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = iter_s ? BUSY : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Result/flag values to capture on entry to DONE.
  always_comb begin
    load_s = 1'b0;
    res_s  = {WIDTH{1'b0}};
    hi_s   = {WIDTH{1'b0}};
    c_s    = 1'b0;
    v_s    = 1'b0;
    err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && !iter_s) begin
          load_s = 1'b1;
          case (alu_ctrl)
            OP_ADD: begin
              res_s = sum_s[WIDTH-1:0];
              c_s   = sum_s[WIDTH];
              v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              res_s = diff_s[WIDTH-1:0];
              c_s   = diff_s[WIDTH];
              v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res_s = a & b;
            OP_OR:  res_s = a | b;
            OP_XOR: res_s = a ^ b;
            OP_NOT: res_s = ~a;
            OP_SHR: res_s = (b >= W_B) ? {WIDTH{1'b0}} : (a >> b);
            OP_SHL: res_s = (b >= W_B) ? {WIDTH{1'b0}} : (a << b);
            OP_DIV: begin
              res_s = {WIDTH{1'b1}};
              hi_s  = a;
              err_s = 1'b1;
            end
            default: begin
              res_s = {{(WIDTH-1){1'b0}}, 1'b1};
              err_s = 1'b1;
            end
          endcase
        end else begin
          load_s = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_r == LAST) begin
          load_s = 1'b1;
          res_s  = acc_s[WIDTH-1:0];
          hi_s   = acc_s[2*WIDTH-1:WIDTH];
          if (op_r == OP_MUL) begin
            c_s = |acc_s[2*WIDTH-1:WIDTH];
          end else begin
            c_s = 1'b0;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
  end

  assign zn_s = zn_flags(res_s);

  // Operand capture, iteration state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      op_r      <= 4'd0;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      result    <= {WIDTH{1'b0}};
      result_hi <= {WIDTH{1'b0}};
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if ((state_r == IDLE) && in_valid) begin
        a_r   <= a;
        b_r   <= b;
        op_r  <= alu_ctrl;
        cnt_r <= {CNT_W{1'b0}};
        acc_r <= (alu_ctrl == OP_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      end else if (state_r == BUSY) begin
        acc_r <= acc_s;
        if (cnt_r != LAST) begin
          cnt_r <= cnt_r + ONE;
        end
      end
      if (load_s) begin
        result    <= res_s;
        result_hi <= hi_s;
        flag_z    <= zn_s[1];
        flag_n    <= zn_s[0];
        flag_c    <= c_s;
        flag_v    <= v_s;
        err       <= err_s;
      end
    end
  end

endmodule
